// File: rtl/prog_tick_pkg.sv
// Shared types for the programmable tick generator: channel run state and mode encoding.
package prog_tick_pkg;

   typedef enum logic {
      MODE_FREE    = 1'b0,
      MODE_ONESHOT = 1'b1
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: a runtime-modulus counter with a shadowed period.
// The period only changes at a wrap or while the channel is idle.
module tick_channel
   import prog_tick_pkg::*;
#(
   parameter int W          = 26,
   parameter int PERIOD_RST = 3
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic         oneshot,
   input  logic         start,
   input  logic         load,
   input  logic [W-1:0] period,
   output logic         tick,
   output logic         busy,
   output logic [W-1:0] count
);

   typedef logic [W-1:0] cnt_t;

   localparam cnt_t RST_PERIOD = cnt_t'(PERIOD_RST);

   state_e state, state_nxt;
   cnt_t   count_q, count_nxt;
   cnt_t   shadow, shadow_nxt;
   cnt_t   active, active_nxt;
   cnt_t   reload;
   logic   tick_q, tick_nxt;
   logic   wrap;
   mode_e  mode;

   assign mode = mode_e'(oneshot);

   // A load on the same edge as a wrap or while idle bypasses the shadow,
   // so the new period is taken directly rather than the stale shadow value.
   always_comb begin
      reload     = load ? period : shadow;
      wrap       = (state == ST_RUN) && (count_q == active);
      state_nxt  = state;
      count_nxt  = count_q;
      tick_nxt   = 1'b0;
      shadow_nxt = reload;
      active_nxt = active;
      if (!en) begin
         state_nxt  = ST_IDLE;
         count_nxt  = '0;
         active_nxt = reload;
      end else begin
         case (state)
            ST_IDLE: begin
               count_nxt  = '0;
               active_nxt = reload;
               if (mode == MODE_FREE || start) begin
                  state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (wrap) begin
                  count_nxt  = '0;
                  tick_nxt   = 1'b1;
                  active_nxt = reload;
                  if (mode == MODE_ONESHOT) begin
                     state_nxt = ST_IDLE;
                  end
               end else begin
                  count_nxt = count_q + cnt_t'(1);
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               count_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         count_q <= '0;
         tick_q  <= 1'b0;
         shadow  <= RST_PERIOD;
         active  <= RST_PERIOD;
      end else begin
         state   <= state_nxt;
         count_q <= count_nxt;
         tick_q  <= tick_nxt;
         shadow  <= shadow_nxt;
         active  <= active_nxt;
      end
   end

   assign tick  = tick_q;
   assign busy  = (state == ST_RUN);
   assign count = count_q;

endmodule

// File: rtl/prog_tick_gen.sv
// Multi-channel programmable tick generator: N_CH independent tick channels
// sharing one clock, with periods and counts packed W bits per channel.
module prog_tick_gen
   import prog_tick_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int W          = 26,
   parameter int PERIOD_RST = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [N_CH-1:0]   en,
   input  logic [N_CH-1:0]   oneshot,
   input  logic [N_CH-1:0]   start,
   input  logic [N_CH-1:0]   load,
   input  logic [N_CH*W-1:0] period,
   output logic [N_CH-1:0]   tick,
   output logic [N_CH-1:0]   busy,
   output logic [N_CH*W-1:0] count
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      tick_channel #(
         .W          (W),
         .PERIOD_RST (PERIOD_RST)
      ) u_ch (
         .clk     (clk),
         .reset_n (reset_n),
         .en      (en[i]),
         .oneshot (oneshot[i]),
         .start   (start[i]),
         .load    (load[i]),
         .period  (period[i*W +: W]),
         .tick    (tick[i]),
         .busy    (busy[i]),
         .count   (count[i*W +: W])
      );
   end

endmodule

// File: tb/tb_prog_tick_gen.sv
// Directed bench for prog_tick_gen with two 8-bit channels; expected values
// are worked out by hand for each step.
module tb_prog_tick_gen;

   localparam int N_CH = 2;
   localparam int W    = 8;

   logic              clk     = 1'b0;
   logic              reset_n = 1'b0;
   logic [N_CH-1:0]   en      = '0;
   logic [N_CH-1:0]   oneshot = '0;
   logic [N_CH-1:0]   start   = '0;
   logic [N_CH-1:0]   load    = '0;
   logic [N_CH*W-1:0] period  = '0;
   logic [N_CH-1:0]   tick;
   logic [N_CH-1:0]   busy;
   logic [N_CH*W-1:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   prog_tick_gen #(
      .N_CH       (N_CH),
      .W          (W),
      .PERIOD_RST (3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .oneshot (oneshot),
      .start   (start),
      .load    (load),
      .period  (period),
      .tick    (tick),
      .busy    (busy),
      .count   (count)
   );

   always #5 clk = ~clk;

   task automatic cycle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      int t1_c[6]  = '{0, 1, 2, 3, 0, 1};
      int t1_t[6]  = '{0, 0, 0, 0, 1, 0};
      int t2_c[7]  = '{0, 1, 2, 3, 4, 5, 0};
      int t2_t[7]  = '{1, 0, 0, 0, 0, 0, 1};
      int t5_c[5]  = '{0, 1, 2, 3, 0};
      int t5_t[5]  = '{0, 0, 0, 0, 1};
      int t6_c0[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
      int t6_t0[9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
      int t6_c1[9] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
      int t6_t1[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
      int t6_b1[9] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
      logic found;

      $display("[TB] start");
      cycle(2);
      check_output("rst_count", count, 0);
      check_output("rst_tick", tick, 0);
      check_output("rst_busy", busy, 0);

      // Free-run on ch0 at the reset period of 3; ch1 stays disabled.
      reset_n = 1'b1;
      en      = 2'b01;
      for (int i = 0; i < 6; i++) begin
         cycle(1);
         check_output($sformatf("t1_cnt0[%0d]", i), count[7:0], t1_c[i]);
         check_output($sformatf("t1_tick0[%0d]", i), tick[0], t1_t[i]);
      end
      check_output("t1_busy0", busy[0], 1);
      check_output("t1_cnt1", count[15:8], 0);
      check_output("t1_tick1", tick[1], 0);
      check_output("t1_busy1", busy[1], 0);

      // Load period 5 mid-count: the current period still wraps at 3.
      load   = 2'b01;
      period = {8'd0, 8'd5};
      cycle(1);
      load = 2'b00;
      check_output("t2_cnt0_a", count[7:0], 2);
      cycle(1);
      check_output("t2_cnt0_b", count[7:0], 3);
      for (int i = 0; i < 7; i++) begin
         cycle(1);
         check_output($sformatf("t2_cnt0[%0d]", i), count[7:0], t2_c[i]);
         check_output($sformatf("t2_tick0[%0d]", i), tick[0], t2_t[i]);
      end

      // One-shot on ch1 with period 2; a second start while busy is ignored.
      en      = 2'b11;
      oneshot = 2'b10;
      load    = 2'b10;
      period  = {8'd2, 8'd5};
      cycle(1);
      load = 2'b00;
      check_output("t3_idle_busy1", busy[1], 0);
      check_output("t3_idle_cnt1", count[15:8], 0);
      start = 2'b10;
      cycle(1);
      start = 2'b00;
      check_output("t3_f1_busy1", busy[1], 1);
      check_output("t3_f1_cnt1", count[15:8], 0);
      cycle(1);
      check_output("t3_f2_busy1", busy[1], 1);
      check_output("t3_f2_cnt1", count[15:8], 1);
      start = 2'b10;
      cycle(1);
      start = 2'b00;
      check_output("t3_f3_busy1", busy[1], 1);
      check_output("t3_f3_cnt1", count[15:8], 2);
      check_output("t3_f3_tick1", tick[1], 0);
      cycle(1);
      check_output("t3_f4_tick1", tick[1], 1);
      check_output("t3_f4_busy1", busy[1], 0);
      check_output("t3_f4_cnt1", count[15:8], 0);
      cycle(1);
      check_output("t3_f5_tick1", tick[1], 0);
      check_output("t3_f5_busy1", busy[1], 0);
      check_output("t3_f5_tick0", tick[0], 1);

      // Period 0 in free-run keeps tick high; disabling clears everything.
      oneshot = 2'b00;
      load    = 2'b10;
      period  = {8'd0, 8'd5};
      cycle(1);
      load = 2'b00;
      check_output("t4_busy1", busy[1], 1);
      check_output("t4_tick1_first", tick[1], 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1);
         check_output($sformatf("t4_tick1[%0d]", i), tick[1], 1);
         check_output($sformatf("t4_cnt1[%0d]", i), count[15:8], 0);
      end
      en = 2'b01;
      cycle(1);
      check_output("t4_dis_cnt1", count[15:8], 0);
      check_output("t4_dis_tick1", tick[1], 0);
      check_output("t4_dis_busy1", busy[1], 0);

      // Asynchronous reset while ch0 is at count 4 of period 5.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (count[7:0] == 8'd4) found = 1'b1;
         else cycle(1);
      end
      check_output("t5_reach_cnt4", found, 1);
      #2 reset_n = 1'b0;
      #1;
      check_output("t5_async_count", count, 0);
      check_output("t5_async_tick", tick, 0);
      check_output("t5_async_busy", busy, 0);
      cycle(1);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle(1);
         check_output($sformatf("t5_cnt0[%0d]", i), count[7:0], t5_c[i]);
         check_output($sformatf("t5_tick0[%0d]", i), tick[0], t5_t[i]);
      end

      // Load 7 on ch0 exactly at its wrap edge while ch1 fires a one-shot of period 1.
      cycle(3);
      check_output("t6_pre_cnt0", count[7:0], 3);
      en      = 2'b11;
      oneshot = 2'b10;
      start   = 2'b10;
      load    = 2'b11;
      period  = {8'd1, 8'd7};
      for (int i = 0; i < 9; i++) begin
         cycle(1);
         if (i == 0) begin
            start = 2'b00;
            load  = 2'b00;
         end
         check_output($sformatf("t6_cnt0[%0d]", i), count[7:0], t6_c0[i]);
         check_output($sformatf("t6_tick0[%0d]", i), tick[0], t6_t0[i]);
         check_output($sformatf("t6_cnt1[%0d]", i), count[15:8], t6_c1[i]);
         check_output($sformatf("t6_tick1[%0d]", i), tick[1], t6_t1[i]);
         check_output($sformatf("t6_busy1[%0d]", i), busy[1], t6_b1[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
